// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with R0 hardwired to zero,
// write-to-read bypass, a per-register busy scoreboard (reserve/release),
// and a synchronous scoreboard flush.
//
// Optional feature macro: REGFILE_SHADOW_BANK_EN
//   Adds a second register bank, selected by o_bank_sel. A context swap is
//   requested with i_ctx_swap and taken once the scoreboard has drained.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_wr_en     write strobe
//   i_wr_addr   write address
//   i_wr_data   write data
//   i_rd_addr   packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   o_rd_data   packed read data, combinational
//   o_rd_busy   busy bit of the register addressed by each read port
//   i_rsv_en    reserve strobe (marks i_rsv_addr as awaiting writeback)
//   i_rsv_addr  register to reserve
//   i_flush     synchronous clear of all busy bits
//   o_busy_vec  full scoreboard, bit 0 always 0
//   o_pend_cnt  number of set busy bits (registered)
//   i_dbg_addr  debug read address
//   o_dbg_data  debug read data, never bypassed
//   i_ctx_swap  (shadow bank only) request a bank swap
//   o_bank_sel  (shadow bank only) currently active bank
module regfile_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int RD_PORTS = 2,
    parameter int BYPASS   = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [ADDR_W-1:0]          i_wr_addr,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic [RD_PORTS*ADDR_W-1:0] i_rd_addr,
    output logic [RD_PORTS*DATA_W-1:0] o_rd_data,
    output logic [RD_PORTS-1:0]        o_rd_busy,
    input  logic                       i_rsv_en,
    input  logic [ADDR_W-1:0]          i_rsv_addr,
    input  logic                       i_flush,
    output logic [(2**ADDR_W)-1:0]     o_busy_vec,
    output logic [ADDR_W:0]            o_pend_cnt,
    input  logic [ADDR_W-1:0]          i_dbg_addr,
`ifdef REGFILE_SHADOW_BANK_EN
    input  logic                       i_ctx_swap,
    output logic                       o_bank_sel,
`endif
    output logic [DATA_W-1:0]          o_dbg_data
);

    localparam int NUM_REGS = 2**ADDR_W;
`ifdef REGFILE_SHADOW_BANK_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    logic [DATA_W-1:0]   r_mem [NUM_BANKS][NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [ADDR_W:0]     r_pend_cnt;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [ADDR_W:0]     w_pend_nxt;
    logic                w_bank;
    logic                w_rsv_en;

`ifdef REGFILE_SHADOW_BANK_EN
    logic r_bank_sel;
    logic r_swap_pend;
    logic w_swap;

    // Reservations are held off while a swap is pending so the scoreboard
    // can drain; the swap itself needs an empty scoreboard and no new producer.
    assign w_rsv_en = i_rsv_en & ~r_swap_pend;
    assign w_swap   = r_swap_pend & (r_pend_cnt == '0) & ~i_rsv_en;
    assign w_bank   = r_bank_sel;
    assign o_bank_sel = r_bank_sel;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bank_sel  <= 1'b0;
            r_swap_pend <= 1'b0;
        end else begin
            if (w_swap) begin
                r_bank_sel <= ~r_bank_sel;
            end
            // A request arriving on the swap edge stays pending for another swap.
            if (i_ctx_swap) begin
                r_swap_pend <= 1'b1;
            end else if (w_swap) begin
                r_swap_pend <= 1'b0;
            end
        end
    end
`else
    assign w_rsv_en = i_rsv_en;
    assign w_bank   = 1'b0;
`endif

    // Register array; R0 is never written so it stays zero after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    r_mem[b][r] <= '0;
                end
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_mem[w_bank][i_wr_addr] <= i_wr_data;
        end
    end

    // Scoreboard next state: flush > reserve > write-release > hold.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (i_flush) begin
                w_busy_nxt[r] = 1'b0;
            end else if (w_rsv_en && (i_rsv_addr == ADDR_W'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end else if (i_wr_en && (i_wr_addr == ADDR_W'(r))) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Count tracks the next busy vector exactly, so it can never wrap.
    always_comb begin
        w_pend_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_pend_nxt = w_pend_nxt + (ADDR_W+1)'(w_busy_nxt[r]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_pend_nxt;
        end
    end

    assign o_busy_vec = r_busy;
    assign o_pend_cnt = r_pend_cnt;

    // Read ports; busy is reported from registered state, never bypassed.
    always_comb begin
        logic [ADDR_W-1:0] v_addr;
        v_addr    = '0;
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            v_addr = i_rd_addr[p*ADDR_W +: ADDR_W];
            if (v_addr == '0) begin
                o_rd_data[p*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && i_wr_en && (i_wr_addr == v_addr)) begin
                o_rd_data[p*DATA_W +: DATA_W] = i_wr_data;
            end else begin
                o_rd_data[p*DATA_W +: DATA_W] = r_mem[w_bank][v_addr];
            end
            o_rd_busy[p] = r_busy[v_addr];
        end
    end

    assign o_dbg_data = r_mem[w_bank][i_dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_wr_en = 1'b0;
    logic [2:0]  i_wr_addr = '0;
    logic [7:0]  i_wr_data = '0;
    logic [5:0]  i_rd_addr = '0;
    logic [15:0] o_rd_data;
    logic [1:0]  o_rd_busy;
    logic        i_rsv_en = 1'b0;
    logic [2:0]  i_rsv_addr = '0;
    logic        i_flush = 1'b0;
    logic [7:0]  o_busy_vec;
    logic [3:0]  o_pend_cnt;
    logic [2:0]  i_dbg_addr = '0;
    logic [7:0]  o_dbg_data;
`ifdef REGFILE_SHADOW_BANK_EN
    logic        i_ctx_swap = 1'b0;
    logic        o_bank_sel;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  wr_tab [1:7];

    regfile_sb #(.DATA_W(8), .ADDR_W(3), .RD_PORTS(2), .BYPASS(1)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_busy  (o_rd_busy),
        .i_rsv_en   (i_rsv_en),
        .i_rsv_addr (i_rsv_addr),
        .i_flush    (i_flush),
        .o_busy_vec (o_busy_vec),
        .o_pend_cnt (o_pend_cnt),
        .i_dbg_addr (i_dbg_addr),
`ifdef REGFILE_SHADOW_BANK_EN
        .i_ctx_swap (i_ctx_swap),
        .o_bank_sel (o_bank_sel),
`endif
        .o_dbg_data (o_dbg_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed=0x%0h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            end
        end
    endtask

    task automatic idle();
        i_wr_en  = 1'b0;
        i_rsv_en = 1'b0;
        i_flush  = 1'b0;
    endtask

    initial begin
        wr_tab[1] = 8'hAA; wr_tab[2] = 8'h55; wr_tab[3] = 8'hF0; wr_tab[4] = 8'h0F;
        wr_tab[5] = 8'h12; wr_tab[6] = 8'h34; wr_tab[7] = 8'h56;

        repeat (2) tick();
        i_rst = 1'b0;
        tick();

        // R3=0x5A with busy[3] set, then async reset mid-cycle
        i_wr_en = 1'b1; i_wr_addr = 3'd3; i_wr_data = 8'h5A;
        i_rsv_en = 1'b1; i_rsv_addr = 3'd3;
        tick();
        idle();
        i_rd_addr = {3'd3, 3'd3};
        #1;
        expect_val(32'h5A); check("pre_rst_r3", o_rd_data[7:0]);
        expect_val(32'h08); check("pre_rst_busy", o_busy_vec);
        expect_val(32'h1);  check("pre_rst_pend", o_pend_cnt);
        #2 i_rst = 1'b1;
        #1;
        expect_val(32'h00); check("rst_rd0", o_rd_data[7:0]);
        expect_val(32'h00); check("rst_rd1", o_rd_data[15:8]);
        expect_val(32'h00); check("rst_busy", o_busy_vec);
        expect_val(32'h0);  check("rst_pend", o_pend_cnt);
        i_rst = 1'b0;
        tick();

        // basic writes R1..R7, then read back on both ports
        for (int i = 1; i < 8; i++) begin
            i_wr_en = 1'b1; i_wr_addr = 3'(i); i_wr_data = wr_tab[i];
            tick();
        end
        idle();
        for (int i = 1; i < 8; i++) begin
            i_rd_addr = {3'(i), 3'(i)};
            #1;
            expect_val(32'(wr_tab[i])); check("wr_rd0", o_rd_data[7:0]);
            expect_val(32'(wr_tab[i])); check("wr_rd1", o_rd_data[15:8]);
        end

        // R0 write discarded
        i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 8'hFF;
        tick();
        idle();
        i_rd_addr = {3'd0, 3'd0}; i_dbg_addr = 3'd0;
        #1;
        expect_val(32'h00); check("r0_rd0", o_rd_data[7:0]);
        expect_val(32'h00); check("r0_dbg", o_dbg_data);

        // bypass: same-cycle write forwarded to read ports, not to debug
        i_rd_addr = {3'd5, 3'd5}; i_dbg_addr = 3'd5;
        i_wr_en = 1'b1; i_wr_addr = 3'd5; i_wr_data = 8'hBE;
        #1;
        expect_val(32'hBE); check("byp_rd0", o_rd_data[7:0]);
        expect_val(32'hBE); check("byp_rd1", o_rd_data[15:8]);
        expect_val(32'h12); check("byp_dbg_old", o_dbg_data);
        tick();
        idle();
        #1;
        expect_val(32'hBE); check("byp_dbg_new", o_dbg_data);
        expect_val(32'hBE); check("byp_rd0_after", o_rd_data[7:0]);

        // scoreboard: reserve R2
        i_rsv_en = 1'b1; i_rsv_addr = 3'd2;
        tick();
        idle();
        i_rd_addr = {3'd3, 3'd2};
        #1;
        expect_val(32'h04); check("rsv2_busy", o_busy_vec);
        expect_val(32'h1);  check("rsv2_pend", o_pend_cnt);
        expect_val(32'h1);  check("rsv2_rd_busy", o_rd_busy);
        // reserve and write R2 together: reserve wins
        i_rsv_en = 1'b1; i_rsv_addr = 3'd2;
        i_wr_en = 1'b1; i_wr_addr = 3'd2; i_wr_data = 8'h99;
        tick();
        idle();
        #1;
        expect_val(32'h04); check("rsvwr2_busy", o_busy_vec);
        expect_val(32'h99); check("rsvwr2_data", o_rd_data[7:0]);
        // write releases
        i_wr_en = 1'b1; i_wr_addr = 3'd2; i_wr_data = 8'h66;
        tick();
        idle();
        #1;
        expect_val(32'h00); check("rel2_busy", o_busy_vec);
        expect_val(32'h0);  check("rel2_pend", o_pend_cnt);
        // reserve R0 ignored
        i_rsv_en = 1'b1; i_rsv_addr = 3'd0;
        tick();
        idle();
        #1;
        expect_val(32'h00); check("rsv0_busy", o_busy_vec);
        expect_val(32'h0);  check("rsv0_pend", o_pend_cnt);

        // reserve A while writing B
        i_rsv_en = 1'b1; i_rsv_addr = 3'd1;
        tick();
        i_rsv_addr = 3'd4;
        i_wr_en = 1'b1; i_wr_addr = 3'd1; i_wr_data = 8'h21;
        tick();
        idle();
        #1;
        expect_val(32'h10); check("rsvA_wrB_busy", o_busy_vec);
        expect_val(32'h1);  check("rsvA_wrB_pend", o_pend_cnt);
        i_wr_en = 1'b1; i_wr_addr = 3'd4; i_wr_data = 8'h44;
        tick();
        idle();

        // flush with coincident write and reserve
        i_rsv_en = 1'b1; i_rsv_addr = 3'd1; tick();
        i_rsv_addr = 3'd4; tick();
        i_rsv_addr = 3'd7; tick();
        idle();
        #1;
        expect_val(32'h92); check("pre_flush_busy", o_busy_vec);
        expect_val(32'h3);  check("pre_flush_pend", o_pend_cnt);
        i_flush = 1'b1; i_rsv_en = 1'b1; i_rsv_addr = 3'd5;
        i_wr_en = 1'b1; i_wr_addr = 3'd4; i_wr_data = 8'h77;
        tick();
        idle();
        i_rd_addr = {3'd4, 3'd4};
        #1;
        expect_val(32'h00); check("flush_busy", o_busy_vec);
        expect_val(32'h0);  check("flush_pend", o_pend_cnt);
        expect_val(32'h77); check("flush_wr_r4", o_rd_data[7:0]);

`ifdef REGFILE_SHADOW_BANK_EN
        i_wr_en = 1'b1; i_wr_addr = 3'd1; i_wr_data = 8'h11; tick();
        idle();
        i_rsv_en = 1'b1; i_rsv_addr = 3'd6; tick();
        idle();
        i_ctx_swap = 1'b1; tick();
        i_ctx_swap = 1'b0;
        // reservation is blocked while swap is pending
        i_rsv_en = 1'b1; i_rsv_addr = 3'd3; tick();
        idle();
        #1;
        expect_val(32'h0);  check("swap_wait_sel", o_bank_sel);
        expect_val(32'h40); check("swap_rsv_blocked", o_busy_vec);
        i_wr_en = 1'b1; i_wr_addr = 3'd6; i_wr_data = 8'h66; tick();
        idle();
        #1;
        expect_val(32'h0);  check("swap_drain_sel", o_bank_sel);
        tick();
        i_rd_addr = {3'd1, 3'd1};
        #1;
        expect_val(32'h1);  check("swap_sel1", o_bank_sel);
        expect_val(32'h00); check("swap_bank1_r1", o_rd_data[7:0]);
        i_ctx_swap = 1'b1; tick();
        i_ctx_swap = 1'b0; tick();
        #1;
        expect_val(32'h0);  check("swap_back_sel", o_bank_sel);
        expect_val(32'h11); check("swap_back_r1", o_rd_data[7:0]);
`endif

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the MAK-8 8x8 register file.
- Provides configurable width, depth and read-port count, with R0 hardwired to zero.
- Adds write-to-read bypass, a per-register busy scoreboard with reserve/release, and a synchronous flush.
- Sits between the decode/issue stage and writeback of the next-generation MAK-8 pipeline; decode uses the busy bits for hazard stalls.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, address width; NUM_REGS = 2**ADDR_W.
- RD_PORTS, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return array contents only.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  RD_PORTS*ADDR_W  packed read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_data  out  RD_PORTS*DATA_W  packed read data; combinational.
- rd_busy  out  RD_PORTS  busy bit of the register addressed by each read port.
- rsv_en  in  1  reserve strobe; marks rsv_addr as awaiting writeback.
- rsv_addr  in  ADDR_W  register to reserve.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- busy_vec  out  NUM_REGS  full scoreboard; bit 0 is always 0.
- pend_cnt  out  ADDR_W+1  number of set busy bits.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data; never bypassed.

Behaviour:
- Reset (rst=1, asynchronous):
  - all registers = 0, busy_vec = 0, pend_cnt = 0.
  - rd_data follows the cleared array.
  - reset mid-reservation discards all pending reservations.
- Write:
  - on a rising clk edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - writes to R0 are discarded.
  - the new value is visible on rd_data one cycle after the edge.
- Read:
  - rd_data[p] = 0 when rd_addr[p]==0.
  - else, if BYPASS=1, wr_en=1 and wr_addr==rd_addr[p], rd_data[p] = wr_data (same cycle).
  - else rd_data[p] = reg[rd_addr[p]].
  - multiple ports reading the same address return identical data.
- Scoreboard, evaluated per register r!=0 on each rising edge:
  - flush=1 → busy[r] <= 0. Flush overrides everything; a coincident write still updates the array.
  - else rsv_en and rsv_addr==r → busy[r] <= 1. A new producer wins over a simultaneous release of the same register.
  - else wr_en and wr_addr==r → busy[r] <= 0.
  - else hold.
  - busy[0] is constant 0; rsv_addr==0 is ignored.
  - a reserve of an already-busy register keeps it busy: single outstanding producer, no counting.
- rd_busy[p] = busy[rd_addr[p]], registered state, not bypassed. The issue stage must treat a same-cycle write as resolving the hazard only when BYPASS=1.
- pend_cnt:
  - registered; equals the popcount of busy_vec after each edge.
  - range 0..NUM_REGS-1.
  - it must never wrap.
- Simultaneous reserve of A and write of B (A!=B): both take effect in the same cycle; pend_cnt unchanged.

Optional Feature:
- Macro: REGFILE_SHADOW_BANK_EN.
- When defined, the block adds:
  - ports ctx_swap (in, 1) and bank_sel (out, 1).
  - a second full register bank.
- All reads and writes target bank[bank_sel].
- A ctx_swap pulse sets an internal swap_pend flag.
- The bank toggles on the first edge where swap_pend=1 and pend_cnt==0 and no rsv_en. swap_pend then clears.
- While swap_pend=1, rsv_en is ignored so the scoreboard drains.
- A flush with swap_pend=1 clears busy, and the swap occurs on the next edge.
- Reset sets bank_sel=0, swap_pend=0 and clears both banks.
- When the macro is undefined, the ports do not exist and the block is single-bank.

Test Plan:
- Reset: assert rst async mid-cycle with R3=0x5A, busy[3]=1 → all rd_data=0x00, busy_vec=0, pend_cnt=0 immediately, without waiting for a clk edge.
- R0 and basic writes:
  - write R1..R7 = 0xAA,0x55,0xF0,0x0F,0x12,0x34,0x56 → every port reads the written value.
  - write R0=0xFF → R0 reads 0x00.
- Bypass (BYPASS=1): rd_addr0=5, wr_en=1, wr_addr=5, wr_data=0xBE in the same cycle → rd_data0=0xBE before the edge; dbg_data (dbg_addr=5) shows the old value until after the edge.
- Scoreboard:
  - reserve R2 → busy_vec=0x04, pend_cnt=1.
  - same-cycle rsv R2 plus write R2 → busy stays 1.
  - next write R2 → busy_vec=0, pend_cnt=0.
  - rsv R0 → busy_vec=0.
- Flush: reserve R1, R4, R7 (pend_cnt=3), then flush with a coincident write R4=0x77 → busy_vec=0, pend_cnt=0, R4=0x77.
- Shadow bank (macro defined):
  - R1=0x11 in bank 0; reserve R6, then ctx_swap → bank_sel stays 0 until R6 is written.
  - on the next edge bank_sel=1 and R1 reads 0x00.
  - a second swap returns R1=0x11.
